// File: rtl/vnu_sched_if.sv
// vnu_sched_if: bundles the scheduler's control, memory, vnux and Q-write signals.
//   master: scheduler view (drives busy/done, reads, vnux operands, Q writes, dec_vec)
//   slave:  environment view (drives start, read data, vnux results, q_ready)
interface vnu_sched_if #(
  parameter int N_VN   = 8,
  parameter int D      = 3,
  parameter int data_w = 6,
  parameter int ext_w  = 3
);
  localparam int AW    = $clog2(N_VN);
  localparam int sum_w = data_w + ext_w;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [data_w-1:0]     l_data;
  logic [data_w*D-1:0]   r_data;
  logic [data_w-1:0]     vnu_l;
  logic [data_w*D-1:0]   vnu_r;
  logic [sum_w*D-1:0]    vnu_q;
  logic                  vnu_dec;
  logic                  q_we;
  logic                  q_ready;
  logic [AW-1:0]         q_addr;
  logic [data_w*D-1:0]   q_data;
  logic [N_VN-1:0]       dec_vec;
  modport master (
    input  start, l_data, r_data, vnu_q, vnu_dec, q_ready,
    output busy, done, rd_en, rd_addr, vnu_l, vnu_r, q_we, q_addr, q_data, dec_vec
  );
  modport slave (
    output start, l_data, r_data, vnu_q, vnu_dec, q_ready,
    input  busy, done, rd_en, rd_addr, vnu_l, vnu_r, q_we, q_addr, q_data, dec_vec
  );
endinterface

// File: rtl/vnu_sched.sv
// vnu_sched: streams N_VN variable nodes through one shared vnux via a 3-stage pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/busy/done, LLR+R reads, vnux operands/results, Q writes, dec_vec
module vnu_sched #(
  parameter int N_VN   = 8,
  parameter int D      = 3,
  parameter int data_w = 6,
  parameter int ext_w  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  vnu_sched_if.master  bus
);
  localparam int AW    = $clog2(N_VN);
  localparam int sum_w = data_w + ext_w;
  localparam logic [AW-1:0] LAST = AW'(N_VN - 1);
  localparam logic signed [sum_w-1:0] HI = sum_w'((1 << (data_w - 1)) - 1);
  localparam logic signed [sum_w-1:0] LO = -HI;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a0_q, a1_q, q_addr_q;
  logic v0_q, v1_q, q_we_q;
  logic [data_w-1:0] l_q;
  logic [data_w*D-1:0] r_q, q_data_q, sat;
  logic [N_VN-1:0] dec_q;
  logic signed [sum_w-1:0] lane;
  logic stall, rd, clr;
  // A pending write that the Q memory refuses freezes the whole pipeline.
  assign stall = q_we_q & ~bus.q_ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd      = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        cnt_d   = '0;
        clr     = 1'b1;
      end
      RUN: if (!stall) begin
        rd      = 1'b1;
        cnt_d   = cnt_q == LAST ? '0 : cnt_q + AW'(1);
        state_d = cnt_q == LAST ? DRAIN : RUN;
      end
      DRAIN: if (q_we_q && bus.q_ready && q_addr_q == LAST) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Symmetric clamp to +-(2^(data_w-1)-1); in-range lanes keep their low bits.
  always_comb begin
    sat  = '0;
    lane = '0;
    for (int i = 0; i < D; i++) begin
      lane = bus.vnu_q[i*sum_w +: sum_w];
      sat[i*data_w +: data_w] = lane > HI ? HI[data_w-1:0] :
                                lane < LO ? LO[data_w-1:0] : lane[data_w-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a0_q     <= '0;
      a1_q     <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      l_q      <= '0;
      r_q      <= '0;
      q_we_q   <= 1'b0;
      q_addr_q <= '0;
      q_data_q <= '0;
      dec_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (clr) dec_q <= '0;
      if (!stall) begin
        v0_q   <= rd;
        a0_q   <= cnt_q;
        v1_q   <= v0_q;
        a1_q   <= a0_q;
        q_we_q <= v1_q;
        if (v0_q) begin
          l_q <= bus.l_data;
          r_q <= bus.r_data;
        end
        if (v1_q) begin
          q_addr_q    <= a1_q;
          q_data_q    <= sat;
          dec_q[a1_q] <= bus.vnu_dec;
        end
      end
    end
  end
  assign bus.busy    = state_q == RUN || state_q == DRAIN;
  assign bus.done    = state_q == DONE;
  assign bus.rd_en   = rd;
  assign bus.rd_addr = cnt_q;
  assign bus.vnu_l   = l_q;
  assign bus.vnu_r   = r_q;
  assign bus.q_we    = q_we_q;
  assign bus.q_addr  = q_addr_q;
  assign bus.q_data  = q_data_q;
  assign bus.dec_vec = dec_q;
endmodule

// File: tb/tb_vnu_sched.sv
// tb_vnu_sched: directed checks of vnu_sched with a behavioural memory and vnux.
module tb_vnu_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, t0 = 0, tests = 0, fails = 0;
  int wr_tot = 0, rd_tot = 0, rd_stall = 0;
  logic rec = 1'b0;
  int l_mem [4];
  int r_mem [4][3];
  logic s_we [32], s_rdy [32], s_rd [32], s_busy [32], s_done [32];
  logic [1:0] s_addr [32];
  logic [17:0] s_data [32];
  logic [5:0] s_vl [32];
  logic [17:0] s_vr [32];
  logic signed [8:0] vs;
  vnu_sched_if #(.N_VN(4), .D(3), .data_w(6), .ext_w(3)) bif ();
  vnu_sched #(.N_VN(4), .D(3), .data_w(6), .ext_w(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [17:0] p3(input int a, input int b, input int c);
    return {6'(c), 6'(b), 6'(a)};
  endfunction
  always @(posedge clk)
    if (bif.rd_en) begin
      bif.l_data <= 6'(l_mem[bif.rd_addr]);
      bif.r_data <= p3(r_mem[bif.rd_addr][0], r_mem[bif.rd_addr][1], r_mem[bif.rd_addr][2]);
    end
  always_comb begin
    vs = $signed(bif.vnu_l) + $signed(bif.vnu_r[5:0]) + $signed(bif.vnu_r[11:6]) + $signed(bif.vnu_r[17:12]);
    bif.vnu_q[8:0]   = vs - $signed(bif.vnu_r[5:0]);
    bif.vnu_q[17:9]  = vs - $signed(bif.vnu_r[11:6]);
    bif.vnu_q[26:18] = vs - $signed(bif.vnu_r[17:12]);
    bif.vnu_dec      = vs[8];
  end
  always @(negedge clk) begin
    if (bif.q_we && bif.q_ready) wr_tot <= wr_tot + 1;
    if (bif.rd_en) rd_tot <= rd_tot + 1;
    if (bif.rd_en && bif.q_we && !bif.q_ready) rd_stall <= rd_stall + 1;
    if (rec && cyc - t0 < 32) begin
      s_we[cyc-t0]   <= bif.q_we;
      s_rdy[cyc-t0]  <= bif.q_ready;
      s_rd[cyc-t0]   <= bif.rd_en;
      s_busy[cyc-t0] <= bif.busy;
      s_done[cyc-t0] <= bif.done;
      s_addr[cyc-t0] <= bif.q_addr;
      s_data[cyc-t0] <= bif.q_data;
      s_vl[cyc-t0]   <= bif.vnu_l;
      s_vr[cyc-t0]   <= bif.vnu_r;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic begin_pass;
    bif.start = 1'b1;
    tick;
    bif.start = 1'b0;
    t0 = cyc - 1;
  endtask
  // Runs cycles 1..24 of a pass, holding q_ready low over [sf,st] and pulsing start at pa.
  task automatic do_pass(input int sf, input int st, input int pa);
    begin_pass;
    rec = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      bif.q_ready = !(c >= sf && c <= st);
      bif.start = (c == pa);
      tick;
    end
    rec = 1'b0;
    bif.start = 1'b0;
    bif.q_ready = 1'b1;
  endtask
  function automatic int n_writes;
    int n = 0;
    for (int c = 1; c <= 24; c++) n += int'(s_we[c] && s_rdy[c]);
    return n;
  endfunction
  function automatic int n_dones;
    int n = 0;
    for (int c = 1; c <= 24; c++) n += int'(s_done[c]);
    return n;
  endfunction
  function automatic int n_reads;
    int n = 0;
    for (int c = 1; c <= 24; c++) n += int'(s_rd[c]);
    return n;
  endfunction
  logic [17:0] ex [4];
  int w0, r0;
  initial begin
    bif.start = 1'b0;
    bif.q_ready = 1'b1;
    bif.l_data = '0;
    bif.r_data = '0;
    l_mem = '{5, 31, -32, -4};
    r_mem = '{'{3, -2, 7}, '{31, 31, 31}, '{-32, -32, -32}, '{1, 2, -3}};
    ex[0] = p3(10, 15, 6);
    ex[1] = p3(31, 31, 31);
    ex[2] = p3(-31, -31, -31);
    ex[3] = p3(-5, -6, -1);
    #1;
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_qwe", 32'(bif.q_we), 0);
    chk("rst_qdata", 32'(bif.q_data), 0);
    chk("rst_dec", 32'(bif.dec_vec), 0);
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (2) tick;
    // Pass 1: nominal, with a stray start mid-pass.
    do_pass(0, -1, 3);
    chk("p1_busy_c1", 32'(s_busy[1]), 1);
    chk("p1_vnu_l_c3", 32'(s_vl[3]), 32'(6'd5));
    chk("p1_vnu_r_c3", 32'(s_vr[3]), 32'(p3(3, -2, 7)));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("p1_we_%0d", k), 32'(s_we[4+k]), 1);
      chk($sformatf("p1_addr_%0d", k), 32'(s_addr[4+k]), k);
      chk($sformatf("p1_data_%0d", k), 32'(s_data[4+k]), 32'(ex[k]));
    end
    chk("p1_we_c8", 32'(s_we[8]), 0);
    chk("p1_done_c7", 32'(s_done[7]), 0);
    chk("p1_done_c8", 32'(s_done[8]), 1);
    chk("p1_busy_c8", 32'(s_busy[8]), 0);
    chk("p1_nwr", n_writes(), 4);
    chk("p1_nrd", n_reads(), 4);
    chk("p1_ndone", n_dones(), 1);
    chk("p1_dec", 32'(bif.dec_vec), 32'h0c);
    repeat (3) tick;
    chk("p1_dec_hold", 32'(bif.dec_vec), 32'h0c);
    // Pass 2: node 0 changed, Q memory refuses node 1 for three cycles.
    l_mem[0] = -10;
    r_mem[0] = '{0, 0, 0};
    w0 = rd_stall;
    do_pass(5, 7, 0);
    chk("p2_data_0", 32'(s_data[4]), 32'(p3(-10, -10, -10)));
    for (int c = 5; c <= 7; c++) begin
      chk($sformatf("p2_stall_we_%0d", c), 32'(s_we[c]), 1);
      chk($sformatf("p2_stall_addr_%0d", c), 32'(s_addr[c]), 1);
      chk($sformatf("p2_stall_data_%0d", c), 32'(s_data[c]), 32'(ex[1]));
      chk($sformatf("p2_stall_rd_%0d", c), 32'(s_rd[c]), 0);
    end
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("p2_wr_%0d", k), 32'(s_we[7+k] && s_rdy[7+k]), 1);
      chk($sformatf("p2_addr_%0d", k), 32'(s_addr[7+k]), k);
      chk($sformatf("p2_data_%0d", k), 32'(s_data[7+k]), 32'(ex[k]));
    end
    chk("p2_rd_in_stall", rd_stall - w0, 0);
    chk("p2_done_c10", 32'(s_done[10]), 0);
    chk("p2_done_c11", 32'(s_done[11]), 1);
    chk("p2_nwr", n_writes(), 4);
    chk("p2_dec", 32'(bif.dec_vec), 32'h0d);
    // Pass 3: reset lands during the write of node 2.
    begin_pass;
    repeat (5) tick;
    chk("p3_we_pre", 32'(bif.q_we), 1);
    chk("p3_addr_pre", 32'(bif.q_addr), 2);
    rst_n = 1'b0;
    #1;
    chk("p3_busy", 32'(bif.busy), 0);
    chk("p3_rd", 32'({bif.rd_en, bif.rd_addr}), 0);
    chk("p3_vnu", 32'({bif.vnu_l, bif.vnu_r}), 0);
    chk("p3_q", 32'({bif.q_we, bif.q_addr, bif.q_data}), 0);
    chk("p3_dec_done", 32'({bif.dec_vec, bif.done}), 0);
    w0 = wr_tot;
    r0 = rd_tot;
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (6) tick;
    chk("p3_no_wr", wr_tot - w0, 0);
    chk("p3_no_rd", rd_tot - r0, 0);
    // Pass 4: full pass after reset.
    do_pass(0, -1, 0);
    chk("p4_addr_0", 32'(s_addr[4]), 0);
    chk("p4_data_0", 32'(s_data[4]), 32'(p3(-10, -10, -10)));
    chk("p4_data_3", 32'(s_data[7]), 32'(ex[3]));
    chk("p4_nwr", n_writes(), 4);
    chk("p4_done_c8", 32'(s_done[8]), 1);
    chk("p4_dec", 32'(bif.dec_vec), 32'h0d);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
